// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned MAX_N = 32;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned id);
    onehot = {{(MAX_N-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Round-robin pick: first set bit of (req & mask) scanning upward from last_id+1 with wrap.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  input  logic [N-1:0]    mask,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  logic [N-1:0] cand_s;
  logic [N-1:0] rot_s;
  int unsigned  start_s;
  int unsigned  off_s;

  // Rotate so the highest-priority requester sits at bit 0, encode, then rotate back.
  always_comb begin
    cand_s  = req & mask;
    start_s = (32'(last_id) + 32'd1) % N;
    rot_s   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      rot_s[i] = cand_s[ID_W'((start_s + 32'(i)) % N)];
    end
    off_s = 32'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = 32'(i);
      end else begin
        off_s = off_s;
      end
    end
    win_valid = |cand_s;
    win_id    = ID_W'((start_s + off_s) % N);
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-port round-robin arbiter with a per-owner burst limit and a burst-extending lock.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int BURST_MAX = 4,
  parameter int ID_W      = $clog2(N),
  parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic [N-1:0]    req,
  input  logic            lock,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  state_e          state_q;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] last_id_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0]    owner_oh_s;
  logic [N-1:0]    mask_s;
  logic            owner_req_s;
  logic            at_limit_s;
  logic            rotate_s;
  logic [ID_W-1:0] win_id_s;
  logic            win_valid_s;

  // At the burst limit the owner is masked out so someone else can win.
  always_comb begin
    owner_oh_s  = N'(onehot(32'(grant_id_q)));
    owner_req_s = |(req & owner_oh_s);
    at_limit_s  = (cnt_q == CNT_W'(BURST_MAX));
    rotate_s    = (state_q == BUSY) && owner_req_s && at_limit_s && !lock;
    mask_s      = rotate_s ? ~owner_oh_s : {N{1'b1}};
  end

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req       (req),
    .last_id   (last_id_q),
    .mask      (mask_s),
    .win_id    (win_id_s),
    .win_valid (win_valid_s)
  );

  // Arbitration FSM: owner, rotation pointer and burst counter.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      grant_id_q <= {ID_W{1'b0}};
      last_id_q  <= ID_W'(N - 1);
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            state_q    <= BUSY;
            grant_id_q <= win_id_s;
            last_id_q  <= win_id_s;
            cnt_q      <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (!owner_req_s) begin
            if (win_valid_s) begin
              grant_id_q <= win_id_s;
              last_id_q  <= win_id_s;
              cnt_q      <= CNT_W'(1);
            end else begin
              state_q    <= IDLE;
              grant_id_q <= {ID_W{1'b0}};
              cnt_q      <= {CNT_W{1'b0}};
            end
          end else if (!at_limit_s || lock) begin
            if (!at_limit_s) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // A lone owner just restarts its burst without a bubble.
            cnt_q <= CNT_W'(1);
            if (win_valid_s) begin
              grant_id_q <= win_id_s;
              last_id_q  <= win_id_s;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_id_q <= {ID_W{1'b0}};
          cnt_q      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs decode straight from registers, so reset clears them without a clock edge.
  always_comb begin
    grant_valid = (state_q == BUSY);
    grant_id    = grant_id_q;
    grant       = grant_valid ? N'(onehot(32'(grant_id_q))) : {N{1'b0}};
  end

endmodule
